nubus_master_watchdog: RTL and testbench

NUBUS_MASTER_WATCHDOG -- requirements
Module: nubus_master_watchdog

---
 rtl/nubus_inc.sv | 21 ++
 rtl/nubus_master_watchdog.sv | 127 ++++++++++++
 tb/tb_nubus_master_watchdog.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/nubus_inc.sv
// Shared NuBus definitions: TM status codes carried with ACK and the master
// watchdog state encoding.
package nubus_inc;

   // TM1/TM0 status codes sampled with an ACK cycle.
   localparam logic [1:0] TMN_COMPLETE        = 2'b00;
   localparam logic [1:0] TMN_ERROR           = 2'b01;
   localparam logic [1:0] TMN_TIMEOUT_ERROR   = 2'b10;
   localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b11;

   typedef enum logic [1:0] {
      MST_IDLE    = 2'd0,
      MST_WAIT    = 2'd1,
      MST_BACKOFF = 2'd2
   } mst_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/nubus_master_watchdog.sv
// NuBus master transaction watchdog: times out missing ACKs, sequences
// try-again-later retries with a backoff delay, and reports the outcome.
module nubus_master_watchdog #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int RETRY_MAX      = 3,
   parameter int BACKOFF_CYCLES = 4
) (
   input  logic       nub_clkn,
   input  logic       nub_resetn,
   input  logic       mst_start,
   input  logic       mst_ack,
   input  logic [1:0] mst_status,
   output logic       mst_busy,
   output logic       mst_done,
   output logic       mst_retry,
   output logic       mst_timeout,
   output logic       mst_error,
   output logic [1:0] mst_retry_cnt
);
   import nubus_inc::*;

   // Counters hold "clocks already spent", so expiry compares against N-1.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] BACKOFF_LAST = 8'(BACKOFF_CYCLES - 1);
   localparam logic [1:0] RETRY_LIMIT  = 2'(RETRY_MAX);

   mst_state_e state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [1:0] retry_cnt_nxt;
   logic       done_nxt, retry_nxt, timeout_nxt, error_nxt;

   always_ff @(negedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state         <= MST_IDLE;
         cnt           <= 8'd0;
         mst_retry_cnt <= 2'd0;
         mst_done      <= 1'b0;
         mst_retry     <= 1'b0;
         mst_timeout   <= 1'b0;
         mst_error     <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         mst_retry_cnt <= retry_cnt_nxt;
         mst_done      <= done_nxt;
         mst_retry     <= retry_nxt;
         mst_timeout   <= timeout_nxt;
         mst_error     <= error_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      retry_cnt_nxt = mst_retry_cnt;
      done_nxt      = 1'b0;
      retry_nxt     = 1'b0;
      timeout_nxt   = 1'b0;
      error_nxt     = 1'b0;

      case (state)
         MST_IDLE: begin
            if (mst_start) begin
               state_nxt = MST_WAIT;
               cnt_nxt   = 8'd0;
            end
         end

         MST_WAIT: begin
            cnt_nxt = sat_inc8(cnt);
            // An ACK on the expiry clock wins over the timeout.
            if (mst_ack) begin
               case (mst_status)
                  TMN_COMPLETE: begin
                     done_nxt      = 1'b1;
                     retry_cnt_nxt = 2'd0;
                     state_nxt     = MST_IDLE;
                     cnt_nxt       = 8'd0;
                  end
                  TMN_TRY_AGAIN_LATER: begin
                     if (mst_retry_cnt < RETRY_LIMIT) begin
                        retry_cnt_nxt = mst_retry_cnt + 2'd1;
                        state_nxt     = MST_BACKOFF;
                        cnt_nxt       = 8'd0;
                     end else begin
                        error_nxt     = 1'b1;
                        retry_cnt_nxt = 2'd0;
                        state_nxt     = MST_IDLE;
                        cnt_nxt       = 8'd0;
                     end
                  end
                  default: begin
                     error_nxt     = 1'b1;
                     retry_cnt_nxt = 2'd0;
                     state_nxt     = MST_IDLE;
                     cnt_nxt       = 8'd0;
                  end
               endcase
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_nxt   = 1'b1;
               retry_cnt_nxt = 2'd0;
               state_nxt     = MST_IDLE;
               cnt_nxt       = 8'd0;
            end
         end

         MST_BACKOFF: begin
            // Retry count is kept so the re-issued start continues the tally.
            if (cnt == BACKOFF_LAST) begin
               retry_nxt = 1'b1;
               state_nxt = MST_IDLE;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = sat_inc8(cnt);
            end
         end

         default: begin
            state_nxt = MST_IDLE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   assign mst_busy = (state != MST_IDLE);

endmodule

// File: tb/tb_nubus_master_watchdog.sv
// Bench for nubus_master_watchdog: directed scenarios plus randomized
// transactions checked against a transaction-level timeline model.
module tb_nubus_master_watchdog;
   import nubus_inc::*;

   localparam int TIMEOUT = 16;
   localparam int RMAX    = 3;
   localparam int BACKOFF = 4;

   localparam logic [3:0] P_NONE  = 4'b0000;
   localparam logic [3:0] P_DONE  = 4'b1000;
   localparam logic [3:0] P_RETRY = 4'b0100;
   localparam logic [3:0] P_TMO   = 4'b0010;
   localparam logic [3:0] P_ERR   = 4'b0001;

   logic       nub_clkn;
   logic       nub_resetn;
   logic       mst_start;
   logic       mst_ack;
   logic [1:0] mst_status;
   logic       mst_busy;
   logic       mst_done;
   logic       mst_retry;
   logic       mst_timeout;
   logic       mst_error;
   logic [1:0] mst_retry_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int model_rc = 0;

   nubus_master_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .RETRY_MAX     (RMAX),
      .BACKOFF_CYCLES(BACKOFF)
   ) dut (
      .nub_clkn     (nub_clkn),
      .nub_resetn   (nub_resetn),
      .mst_start    (mst_start),
      .mst_ack      (mst_ack),
      .mst_status   (mst_status),
      .mst_busy     (mst_busy),
      .mst_done     (mst_done),
      .mst_retry    (mst_retry),
      .mst_timeout  (mst_timeout),
      .mst_error    (mst_error),
      .mst_retry_cnt(mst_retry_cnt)
   );

   initial nub_clkn = 1'b1;
   always #5 nub_clkn = ~nub_clkn;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [1:0] rstat();
      return 2'($urandom_range(0, 3));
   endfunction

   task automatic check_outputs(input string tag, input logic e_busy, input logic [3:0] e_pulse,
                                input int e_rc);
      chk({tag, ".busy"}, {7'd0, mst_busy}, {7'd0, e_busy});
      chk({tag, ".pulse"}, {4'd0, mst_done, mst_retry, mst_timeout, mst_error}, {4'd0, e_pulse});
      chk({tag, ".rc"}, {6'd0, mst_retry_cnt}, 8'(e_rc));
   endtask

   // Drive one sampling edge worth of inputs, then check what follows it.
   task automatic cyc(input logic s, input logic a, input logic [1:0] st, input logic e_busy,
                      input logic [3:0] e_pulse, input int e_rc, input string tag);
      mst_start  = s;
      mst_ack    = a;
      mst_status = st;
      @(negedge nub_clkn);
      #1;
      check_outputs(tag, e_busy, e_pulse, e_rc);
   endtask

   task automatic idle(input int gap, input bit noise);
      for (int g = 0; g < gap; g++)
         cyc(1'b0, noise ? rbit() : 1'b0, rstat(), 1'b0, P_NONE, model_rc, "idle");
   endtask

   // One issued transaction. delay = clocks from start to ACK; delay > TIMEOUT means no ACK.
   task automatic run_attempt(input int delay, input logic [1:0] status, input bit noise,
                              output bit retried);
      int         resolve;
      bit         got_ack;
      logic       e_busy;
      logic [3:0] e_pulse;
      retried = 1'b0;
      got_ack = (delay <= TIMEOUT);
      resolve = got_ack ? delay : TIMEOUT;
      cyc(1'b1, noise ? rbit() : 1'b0, rstat(), 1'b1, P_NONE, model_rc, "start");
      for (int k = 1; k < resolve; k++)
         cyc(noise ? rbit() : 1'b0, 1'b0, rstat(), 1'b1, P_NONE, model_rc, "wait");
      e_busy = 1'b0;
      if (!got_ack) begin
         e_pulse  = P_TMO;
         model_rc = 0;
      end else if (status == TMN_COMPLETE) begin
         e_pulse  = P_DONE;
         model_rc = 0;
      end else if (status == TMN_TRY_AGAIN_LATER && model_rc < RMAX) begin
         e_pulse  = P_NONE;
         e_busy   = 1'b1;
         model_rc = model_rc + 1;
         retried  = 1'b1;
      end else begin
         e_pulse  = P_ERR;
         model_rc = 0;
      end
      cyc(noise ? rbit() : 1'b0, got_ack, got_ack ? status : rstat(), e_busy, e_pulse,
          model_rc, "resolve");
      if (retried) begin
         for (int j = 1; j <= BACKOFF; j++)
            cyc(noise ? rbit() : 1'b0, noise ? rbit() : 1'b0, rstat(), (j < BACKOFF),
                (j == BACKOFF) ? P_RETRY : P_NONE, model_rc, "backoff");
      end
   endtask

   task automatic mid_reset(input string tag);
      #2;
      nub_resetn = 1'b0;
      #1;
      check_outputs({tag, ".assert"}, 1'b0, P_NONE, 0);
      model_rc = 0;
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, rstat(), 1'b0, P_NONE, 0, {tag, ".held"});
      @(posedge nub_clkn);
      #1;
      nub_resetn = 1'b1;
      idle(3, 1'b1);
   endtask

   initial begin
      bit r;
      nub_resetn = 1'b0;
      mst_start  = 1'b0;
      mst_ack    = 1'b0;
      mst_status = TMN_COMPLETE;
      #1;
      check_outputs("reset", 1'b0, P_NONE, 0);
      repeat (2) @(negedge nub_clkn);
      @(posedge nub_clkn);
      #1;
      nub_resetn = 1'b1;

      // First start after reset; ACK complete 5 clocks later.
      run_attempt(5, TMN_COMPLETE, 1'b0, r);
      idle(2, 1'b0);
      // No ACK: timeout on clock 16; ACK on clock 15 and on the expiry clock 16.
      run_attempt(TIMEOUT + 1, TMN_COMPLETE, 1'b0, r);
      idle(1, 1'b0);
      run_attempt(TIMEOUT - 1, TMN_COMPLETE, 1'b0, r);
      run_attempt(TIMEOUT, TMN_COMPLETE, 1'b0, r);
      idle(1, 1'b0);
      // Four try-again-later ACKs, each followed by a re-start.
      for (int i = 0; i < 4; i++) run_attempt(2, TMN_TRY_AGAIN_LATER, 1'b0, r);
      idle(1, 1'b0);
      // Error codes with stray starts during WAIT.
      run_attempt(6, TMN_ERROR, 1'b1, r);
      run_attempt(3, TMN_TIMEOUT_ERROR, 1'b1, r);
      idle(1, 1'b0);

      // Reset in the middle of WAIT.
      cyc(1'b1, 1'b0, TMN_COMPLETE, 1'b1, P_NONE, model_rc, "rw.start");
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, TMN_COMPLETE, 1'b1, P_NONE, model_rc, "rw.wait");
      mid_reset("rst_wait");
      run_attempt(4, TMN_COMPLETE, 1'b0, r);

      // Reset in the middle of BACKOFF with a nonzero retry count.
      cyc(1'b1, 1'b0, TMN_COMPLETE, 1'b1, P_NONE, model_rc, "rb.start");
      cyc(1'b0, 1'b1, TMN_TRY_AGAIN_LATER, 1'b1, P_NONE, 1, "rb.ack");
      for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, TMN_COMPLETE, 1'b1, P_NONE, 1, "rb.backoff");
      mid_reset("rst_backoff");
      run_attempt(7, TMN_COMPLETE, 1'b0, r);

      // Randomized transactions with stray inputs in ignored states.
      for (int t = 0; t < 300; t++) begin
         int         d;
         int         sel;
         logic [1:0] st;
         sel = int'($urandom_range(0, 9));
         if (sel < 4)      st = TMN_TRY_AGAIN_LATER;
         else if (sel < 7) st = TMN_COMPLETE;
         else if (sel < 8) st = TMN_ERROR;
         else              st = TMN_TIMEOUT_ERROR;
         d = int'($urandom_range(1, TIMEOUT + 3));
         run_attempt(d, st, 1'b1, r);
         idle(int'($urandom_range(0, 3)), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

endmodule
